// File: rtl/seq_fault_injector.sv
// Time-controlled multi-slot fault injector: each slot waits, applies a stuck-at
// or bit-flip fault to one data bit for a programmed number of cycles, then retires.
module seq_fault_injector #(
  parameter int WIDTH      = 8,
  parameter int NUM_FAULTS = 2,
  parameter int CNT_W      = 8,
  parameter int LOC_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int SLOT_W     = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SLOT_W-1:0]     cfg_slot,
  input  logic [LOC_W-1:0]      cfg_loc,
  input  logic [1:0]            cfg_type,
  input  logic [CNT_W-1:0]      cfg_delay,
  input  logic [CNT_W-1:0]      cfg_dur,
  input  logic                  arm,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic [NUM_FAULTS-1:0] active,
  output logic [NUM_FAULTS-1:0] done,
  output logic [CNT_W-1:0]      fault_count
);

  localparam int unsigned NF_U = NUM_FAULTS;
  localparam int unsigned W_U  = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t           r_state [NUM_FAULTS];
  logic [1:0]       r_type  [NUM_FAULTS];
  logic [LOC_W-1:0] r_loc   [NUM_FAULTS];
  logic [CNT_W-1:0] r_delay [NUM_FAULTS];
  logic [CNT_W-1:0] r_dur   [NUM_FAULTS];
  logic [CNT_W-1:0] r_cnt   [NUM_FAULTS];
  logic [WIDTH-1:0] r_data_out;
  logic [CNT_W-1:0] r_fault_count;

  logic [NUM_FAULTS-1:0] w_sel;
  logic [NUM_FAULTS-1:0] w_idle;
  logic [NUM_FAULTS-1:0] w_active;
  logic [NUM_FAULTS-1:0] w_done;
  logic                  w_ready;
  logic                  w_cfg_wr;
  logic [WIDTH-1:0]      w_faulted;

  // An out-of-range slot index matches no slot, so it reads as not ready.
  always_comb begin
    w_sel    = '0;
    w_idle   = '0;
    w_active = '0;
    w_done   = '0;
    for (int unsigned i = 0; i < NF_U; i++) begin
      w_sel[i]    = (32'(cfg_slot) == i);
      w_idle[i]   = (r_state[i] == S_IDLE);
      w_active[i] = (r_state[i] == S_ACTIVE);
      w_done[i]   = (r_state[i] == S_DONE);
    end
    w_ready  = |(w_sel & (w_idle | w_done));
    w_cfg_wr = cfg_valid & w_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NF_U; i++) begin
        r_state[i] <= S_IDLE;
        r_type[i]  <= '0;
        r_loc[i]   <= '0;
        r_delay[i] <= '0;
        r_dur[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NF_U; i++) begin
        if (clear) begin
          r_state[i] <= S_IDLE;
          r_cnt[i]   <= '0;
        end else if (w_cfg_wr && w_sel[i]) begin
          r_type[i]  <= cfg_type;
          r_loc[i]   <= cfg_loc;
          r_delay[i] <= cfg_delay;
          r_dur[i]   <= cfg_dur;
          r_state[i] <= S_IDLE;
          r_cnt[i]   <= '0;
        end else begin
          case (r_state[i])
            S_IDLE: begin
              if (arm && (r_type[i] != 2'b00)) begin
                r_state[i] <= S_WAIT;
                r_cnt[i]   <= r_delay[i];
              end
            end
            S_WAIT: begin
              if (r_cnt[i] == '0) begin
                r_state[i] <= S_ACTIVE;
                r_cnt[i]   <= r_dur[i];
              end else begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
              end
            end
            S_ACTIVE: begin
              // A zero duration means the fault is permanent.
              if (r_dur[i] != '0) begin
                if (r_cnt[i] == CNT_W'(1)) begin
                  r_state[i] <= S_DONE;
                end else begin
                  r_cnt[i] <= r_cnt[i] - 1'b1;
                end
              end
            end
            S_DONE: begin
            end
            default: r_state[i] <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Walk slots from highest to lowest index so the lowest active slot on a bit wins.
  always_comb begin
    w_faulted = data_in;
    for (int unsigned k = 0; k < NF_U; k++) begin
      if (w_active[NF_U-1-k] && (32'(r_loc[NF_U-1-k]) < W_U)) begin
        case (r_type[NF_U-1-k])
          2'b01:   w_faulted[r_loc[NF_U-1-k]] = 1'b0;
          2'b10:   w_faulted[r_loc[NF_U-1-k]] = 1'b1;
          2'b11:   w_faulted[r_loc[NF_U-1-k]] = ~data_in[r_loc[NF_U-1-k]];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out    <= '0;
      r_fault_count <= '0;
    end else begin
      r_data_out <= w_faulted;
      if (clear) begin
        r_fault_count <= '0;
      end else if ((|w_active) && (r_fault_count != '1)) begin
        r_fault_count <= r_fault_count + 1'b1;
      end
    end
  end

  assign cfg_ready   = w_ready;
  assign data_out    = r_data_out;
  assign active      = w_active;
  assign done        = w_done;
  assign fault_count = r_fault_count;

endmodule

// File: tb/tb_seq_fault_injector.sv
// Bench for seq_fault_injector: directed scenarios plus random traffic, checked
// against a timeline model that derives each slot's phase from its arm edge.
module tb_seq_fault_injector;

  localparam int NF   = 2;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cfg_valid, cfg_ready, arm, clear;
  logic [1:0] cfg_slot;
  logic [2:0] cfg_loc;
  logic [1:0] cfg_type;
  logic [7:0] cfg_delay, cfg_dur, din, dout, fc;
  logic [1:0] act, dn;

  logic       b_valid, b_ready, b_arm, b_clear;
  logic [0:0] b_slot;
  logic [2:0] b_loc;
  logic [1:0] b_type;
  logic [2:0] b_delay, b_dur, b_fc;
  logic [7:0] b_din, b_dout;
  logic [1:0] b_act, b_dn;

  seq_fault_injector #(.WIDTH(8), .NUM_FAULTS(2), .CNT_W(8), .SLOT_W(2)) dut (
    .clk(clk), .reset(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_slot(cfg_slot), .cfg_loc(cfg_loc), .cfg_type(cfg_type),
    .cfg_delay(cfg_delay), .cfg_dur(cfg_dur), .arm(arm), .clear(clear),
    .data_in(din), .data_out(dout), .active(act), .done(dn), .fault_count(fc)
  );

  seq_fault_injector #(.WIDTH(8), .NUM_FAULTS(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_slot(b_slot), .cfg_loc(b_loc), .cfg_type(b_type),
    .cfg_delay(b_delay), .cfg_dur(b_dur), .arm(b_arm), .clear(b_clear),
    .data_in(b_din), .data_out(b_dout), .active(b_act), .done(b_dn), .fault_count(b_fc)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference: a slot is described by its config and the edge it was armed on.
  int m_type [NF];
  int m_loc  [NF];
  int m_dly  [NF];
  int m_dur  [NF];
  int m_at   [NF];
  bit m_armed[NF];
  int m_n;
  int m_cnt;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 idle, 1 wait, 2 active, 3 done
  function automatic int st(input int i);
    int k;
    if (!m_armed[i]) return 0;
    k = m_n - m_at[i];
    if (k <= m_dly[i]) return 1;
    if (m_dur[i] == 0 || k <= m_dly[i] + m_dur[i]) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_type[i] = 0; m_loc[i] = 0; m_dly[i] = 0; m_dur[i] = 0;
      m_at[i] = 0; m_armed[i] = 0;
    end
    m_n = 0; m_cnt = 0; m_dout = 8'h00;
  endtask

  task automatic step(input logic v, input int slot, input int typ, input int loc,
                      input int dly, input int dur, input logic a, input logic c,
                      input logic [7:0] d);
    int s[NF];
    int tv, lv;
    logic [7:0] e;
    logic [1:0] ea, ed;
    bit any, rdy;
    tv = typ; lv = loc;
    cfg_valid = v; cfg_slot = slot[1:0]; cfg_type = tv[1:0]; cfg_loc = lv[2:0];
    cfg_delay = dly[7:0]; cfg_dur = dur[7:0]; arm = a; clear = c; din = d;
    for (int i = 0; i < NF; i++) s[i] = st(i);
    rdy = 0;
    if (slot < NF) rdy = (s[slot] == 0) || (s[slot] == 3);
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
    e = d; any = 0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (s[i] == 2) begin
        any = 1;
        case (m_type[i])
          1: e[m_loc[i]] = 1'b0;
          2: e[m_loc[i]] = 1'b1;
          3: e[m_loc[i]] = ~d[m_loc[i]];
          default: ;
        endcase
      end
    end
    if (c) begin
      m_cnt = 0;
      for (int i = 0; i < NF; i++) m_armed[i] = 0;
    end else begin
      if (any && m_cnt < CMAX) m_cnt++;
      if (a) begin
        for (int i = 0; i < NF; i++) begin
          if (s[i] == 0 && m_type[i] != 0) begin
            m_armed[i] = 1; m_at[i] = m_n + 1;
          end
        end
      end
      if (v && rdy) begin
        m_type[slot] = typ; m_loc[slot] = loc; m_dly[slot] = dly; m_dur[slot] = dur;
        m_armed[slot] = 0;
      end
    end
    m_n++;
    m_dout = e;
    @(posedge clk); #1;
    for (int i = 0; i < NF; i++) begin
      ea[i] = (st(i) == 2);
      ed[i] = (st(i) == 3);
    end
    chk("data_out", {24'd0, dout}, {24'd0, m_dout});
    chk("active", {30'd0, act}, {30'd0, ea});
    chk("done", {30'd0, dn}, {30'd0, ed});
    chk("fault_count", {24'd0, fc}, m_cnt);
  endtask

  task automatic idle(input logic [7:0] d, input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic cfgw(input int slot, input int typ, input int loc, input int dly,
                      input int dur, input logic [7:0] d);
    step(1, slot, typ, loc, dly, dur, 0, 0, d);
  endtask

  initial begin
    int r;
    rst_n = 0;
    cfg_valid = 0; cfg_slot = 0; cfg_loc = 0; cfg_type = 0; cfg_delay = 0; cfg_dur = 0;
    arm = 0; clear = 0; din = 8'h5A;
    b_valid = 0; b_slot = 0; b_loc = 0; b_type = 0; b_delay = 0; b_dur = 0;
    b_arm = 0; b_clear = 0; b_din = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", {24'd0, dout}, 32'h0);
    chk("rst_active", {30'd0, act}, 32'h0);
    chk("rst_done", {30'd0, dn}, 32'h0);
    chk("rst_fault_count", {24'd0, fc}, 32'h0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'h1);
    rst_n = 1;

    // Timed stuck-at-0 window
    cfgw(0, 1, 3, 0, 2, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
    idle(8'hFF, 2);
    chk("tp1_dout_e2", {24'd0, dout}, 32'hF7);
    idle(8'hFF, 3);
    chk("tp1_count", {24'd0, fc}, 32'd2);
    chk("tp1_done", {30'd0, dn}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'hFF);

    // Two permanent faults with staggered delays, then clear
    cfgw(0, 3, 0, 2, 0, 8'h00);
    cfgw(1, 2, 7, 4, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    idle(8'h00, 9);
    chk("tp2_dout_held", {24'd0, dout}, 32'h81);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle(8'h00, 1);
    chk("tp2_dout_clr", {24'd0, dout}, 32'h00);
    chk("tp2_count_clr", {24'd0, fc}, 32'h00);

    // Same-bit conflict: slot0 wins
    cfgw(0, 1, 5, 0, 0, 8'hFF);
    cfgw(1, 2, 5, 0, 0, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
    idle(8'hFF, 3);
    chk("tp3_conflict", {24'd0, dout}, 32'hDF);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'hFF);
    cfgw(0, 0, 5, 0, 0, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
    idle(8'hFF, 3);
    chk("tp3_slot1_only", {24'd0, dout}, 32'hFF);
    idle(8'h00, 2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Write to a busy slot and to an out-of-range slot are refused
    cfgw(1, 0, 0, 0, 0, 8'hFF);
    cfgw(0, 1, 2, 5, 3, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
    cfgw(0, 2, 2, 5, 3, 8'hFF);
    idle(8'hFF, 6);
    chk("tp4_orig_type", {24'd0, dout}, 32'hFB);
    cfgw(2, 3, 1, 0, 0, 8'hFF);
    idle(8'hFF, 4);

    // Asynchronous reset while a fault is active
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'hAA);
    cfgw(0, 3, 1, 0, 0, 8'hAA);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'hAA);
    idle(8'hAA, 3);
    chk("tp5_pre_reset", {24'd0, dout}, 32'hA8);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_data_out", {24'd0, dout}, 32'h0);
    chk("async_rst_active", {30'd0, act}, 32'h0);
    chk("async_rst_fault_count", {24'd0, fc}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h5A);
    idle(8'hC3, 1);
    idle(8'h3C, 2);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 99);
      if (r < 14)
        step(1, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 7),
             $urandom_range(0, 6), $urandom_range(0, 5), 0, 0, 8'($urandom));
      else if (r < 26) step(0, 0, 0, 0, 0, 0, 1, 0, 8'($urandom));
      else if (r < 29) step(0, 0, 0, 0, 0, 0, 0, 1, 8'($urandom));
      else if (r < 31) step(0, 0, 0, 0, 0, 0, 1, 1, 8'($urandom));
      else if (r < 33)
        step(1, $urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 7),
             $urandom_range(0, 6), $urandom_range(0, 5), 0, 1, 8'($urandom));
      else idle(8'($urandom), 1);
    end

    // Narrow counter saturation and arm/clear on the same edge
    b_valid = 1; b_slot = 1'b0; b_type = 2'b11; b_loc = 3'd0; b_delay = 3'd0; b_dur = 3'd0;
    @(posedge clk); #1;
    b_valid = 0; b_arm = 1;
    @(posedge clk); #1;
    b_arm = 0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("b_count_sat", {29'd0, b_fc}, 32'd7);
    chk("b_active", {30'd0, b_act}, 32'h1);
    chk("b_dout_flip", {24'd0, b_dout}, 32'h01);
    b_arm = 1; b_clear = 1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    b_arm = 0; b_clear = 0; b_din = 8'h3C;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("b_armclr_active", {30'd0, b_act}, 32'h0);
    chk("b_armclr_done", {30'd0, b_dn}, 32'h0);
    chk("b_armclr_count", {29'd0, b_fc}, 32'h0);
    chk("b_armclr_dout", {24'd0, b_dout}, 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_fault_injector.md
Name: seq_fault_injector

Overview:
- Parametrised, time-controlled successor to the combinational single-fault injector.
- Holds NUM_FAULTS independently configured fault slots. Each slot has a bit location, a fault type, a start delay and a duration.
- Applies active faults to a WIDTH-bit data word and registers the result.
- Sits between a stimulus source and the DUT input in fault-campaign benches and gate-level fault studies.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_FAULTS, 2, number of independent fault slots.
- CNT_W, 8, width of the delay, duration and fault_count counters.
- LOC_W, $clog2(WIDTH), width of the bit-location field (derived).
- SLOT_W, $clog2(NUM_FAULTS) with a minimum of 1, width of the slot index (derived).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  selected slot can accept configuration.
- cfg_slot  input  SLOT_W  slot index for the write.
- cfg_loc  input  LOC_W  faulted bit position.
- cfg_type  input  2  fault type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip.
- cfg_delay  input  CNT_W  cycles spent in WAIT before the fault starts.
- cfg_dur  input  CNT_W  active cycles; 0 = permanent.
- arm  input  1  start all configured slots.
- clear  input  1  abort all slots and zero fault_count.
- data_in  input  WIDTH  fault-free word.
- data_out  output  WIDTH  registered, possibly faulted word.
- active  output  NUM_FAULTS  per-slot flag: slot is in ACTIVE.
- done  output  NUM_FAULTS  per-slot flag: slot is in DONE.
- fault_count  output  CNT_W  cycles with at least one slot ACTIVE, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All slots go to IDLE with type 00, loc 0, delay 0, dur 0 and counter 0.
  - data_out, active, done and fault_count = 0.
  - cfg_ready = 1.
- Per-slot FSM states: IDLE, WAIT, ACTIVE, DONE.
- Configuration:
  - cfg_ready = 1 when slot cfg_slot is in IDLE or DONE.
  - A write occurs when cfg_valid & cfg_ready. It stores loc/type/delay/dur and moves the slot to IDLE.
  - cfg_slot >= NUM_FAULTS gives cfg_ready = 0 and the write is ignored.
  - A write to a busy (WAIT/ACTIVE) slot is ignored and its configuration is unchanged.
- Arm:
  - On an edge with arm=1, every IDLE slot whose type != 00 goes to WAIT and loads cnt = delay.
  - Slots in any other state ignore arm.
  - Type-00 slots stay in IDLE.
- WAIT:
  - If cnt == 0, go to ACTIVE and load cnt = dur; otherwise cnt decrements.
  - The first ACTIVE cycle is therefore delay+1 edges after the arm edge.
- ACTIVE:
  - If dur == 0, the slot stays ACTIVE until clear or reset.
  - Otherwise, on each edge: if cnt == 1, go to DONE; else cnt decrements. The slot spends exactly dur cycles in ACTIVE.
- DONE: holds until reconfigured, cleared or reset.
- Clear:
  - Synchronous. All slots go to IDLE, configuration is kept, fault_count is set to 0.
  - clear has priority over arm and over a cfg write on the same edge; the cfg write is dropped.
- Datapath:
  - Each edge: data_out <= data_in with the faults of all slots ACTIVE in the current cycle applied. One-cycle latency.
  - The first faulted data_out value is seen delay+2 edges after the arm edge.
  - Per-bit conflict: the lowest-index ACTIVE slot targeting that bit decides the bit.
  - loc >= WIDTH: the slot runs its FSM normally but has no datapath effect.
- fault_count: increments on each edge where any slot is ACTIVE; saturates at 2^CNT_W - 1.

Test Plan (WIDTH=8, NUM_FAULTS=2, CNT_W=8 unless stated):
- Slot0 SA0, loc 3, delay 0, dur 2; data_in=0xFF; arm at edge E0 -> data_out=0xFF, then 0xF7 at E2 and E3, 0xFF from E4; done[0]=1 from E3; fault_count=2.
- Slot0 flip loc 0, delay 2; slot1 SA1 loc 7, delay 4; both dur 0; data_in=0x00; arm at E0 -> data_out=0x01 from E4, 0x81 from E6 and held; clear at E10 -> data_out=0x00 at E11, fault_count=0, active=00.
- Both slots loc 5, slot0 SA0, slot1 SA1, delay 0, dur 0; data_in=0xFF -> data_out=0xDF (slot0 wins); with slot0 type 00 re-run -> 0xFF.
- Slot0 in WAIT with delay 5; cfg_valid to slot0 with type 10 -> cfg_ready=0 and the fault later applied is still the original type; cfg_slot=2 -> cfg_ready=0.
- reset driven low mid-ACTIVE, asynchronously between edges -> data_out, active and fault_count = 0 immediately, without waiting for an edge; after release, arm alone -> no slot leaves IDLE (types cleared) and data_out tracks data_in with one-cycle latency.
- CNT_W=3, permanent flip for 10 cycles -> fault_count stops at 7; arm and clear on the same edge -> all slots IDLE.
